fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC loaded on reset; it must be word-aligned.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the number of fetch buffer entries; legal values are 2 or 4.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins fetching.
REQ-006 SHALL have port imem_addr  output  16  byte address to instruction memory, which reads combinationally.
REQ-007 SHALL have port imem_rdata  input  32  instruction word at imem_addr, same cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  16  redirect target byte address.
REQ-010 SHALL have port instr_valid  output  1  buffer head valid.
REQ-011 SHALL have port instr_ready  input  1  downstream accepts the head.
REQ-012 SHALL have port instr  output  32  head instruction word.
REQ-013 SHALL have port instr_pc  output  16  head instruction address.
REQ-014 SHALL have port busy  output  1  high in FETCH or STALL.
REQ-015 SHALL have port misalign_err  output  1  sticky misaligned-redirect flag.

Function
REQ-016 SHALL implement the states IDLE, FETCH, STALL and ERROR.
REQ-017 In every state, imem_addr SHALL equal the current PC.
REQ-018 IDLE SHALL go to FETCH on the cycle after start=1; start SHALL be ignored in all other states.
REQ-019 In FETCH, when the buffer is not full (or a pop occurs that cycle), the block SHALL push {PC, imem_rdata} and set PC to PC+4.
REQ-020 A pop is instr_valid && instr_ready, and the buffer SHALL hold the entry being popped until the next edge.
REQ-021 FETCH SHALL go to STALL when the buffer becomes full with no pop; STALL SHALL return to FETCH on the first pop, and no push SHALL occur in that pop cycle.
REQ-022 Latency: start in cycle N SHALL give instr_valid=1 in cycle N+2 with instr_pc=RESET_PC.
REQ-023 While instr_valid=1 and instr_ready=0, instr and instr_pc SHALL stay stable.
REQ-024 PC arithmetic SHALL be 16-bit modulo, so 16'hFFFC+4 wraps to 16'h0000 with no error.
REQ-025 Redirect SHALL have the highest priority.
REQ-026 In FETCH or STALL, a redirect with redirect_pc[1:0]==0 SHALL flush the buffer, load PC with redirect_pc, suppress that cycle's push and pop, and move to FETCH; instr_valid SHALL be 0 the next cycle.
REQ-027 In IDLE, an aligned redirect SHALL load PC and remain in IDLE.
REQ-028 A redirect with redirect_pc[1:0]!=0 in any state except ERROR SHALL flush the buffer, move to ERROR and set misalign_err.
REQ-029 In ERROR, instr_valid and busy SHALL be 0, and the block SHALL ignore start and redirect until reset.
REQ-030 Redirect and start in the same IDLE cycle SHALL load PC and then fetch from redirect_pc.

Reset
REQ-031 While rst=1, regardless of clk, the block SHALL set: state IDLE, PC=RESET_PC, buffer empty, instr_valid=0, instr=0, instr_pc=0, busy=0, misalign_err=0.
REQ-032 Reset asserted mid-fetch SHALL discard all buffered entries; the first fetch after release SHALL require a new start.

Configuration
REQ-033 With macro FETCH_PERF_CNT_EN defined, the block SHALL add outputs fetch_count[31:0] (pushes) and stall_count[31:0] (cycles in STALL).
REQ-034 With FETCH_PERF_CNT_EN defined, both counters SHALL reset to 0 and wrap modulo 2^32.
REQ-035 Without FETCH_PERF_CNT_EN, these ports and counters SHALL be absent.

Structure
REQ-036 Package fetch_pkg SHALL hold the state enum fetch_state_t, ADDR_W=16, XLEN=32, and the buffer entry struct {pc, instr}.
REQ-037 Sub-module fetch_buf SHALL be the synchronous FIFO of BUF_DEPTH entries with push, pop, flush, full and empty.

Verification
REQ-038 Scenario: reset, start, instr_ready=1 held -> instr_pc sequence 0,4,8,12 on consecutive cycles from cycle N+2.
REQ-039 Scenario: instr_ready=0 after start -> buffer fills, state STALL, imem_addr frozen at 16'h0008 (BUF_DEPTH=2); raising ready -> instr_pc 0 then 4 then 8.
REQ-040 Scenario: redirect_pc=16'h0020 during FETCH -> next cycle instr_valid=0, then instr_pc=16'h0020.
REQ-041 Scenario: redirect_pc=16'h0022 -> ERROR, misalign_err=1, instr_valid=0; a later start is ignored.
REQ-042 Scenario: redirect_pc=16'hFFF8 -> instr_pc sequence FFF8, FFFC, 0000.
REQ-043 Scenario: rst asserted between edges while the buffer is full -> all outputs zero immediately, state IDLE, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch sequencer.
package fetch_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned XLEN   = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_STALL,
      ST_ERROR
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [XLEN-1:0]   instr;
   } buf_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Fetch buffer: small synchronous FIFO of {pc, instr} entries with flush.
module fetch_buf
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic       i_flush,
   input  buf_entry_t i_data,
   output buf_entry_t o_head,
   output logic       o_full,
   output logic       o_afull,
   output logic       o_empty
);

   localparam int unsigned PW    = $clog2(DEPTH);
   localparam int unsigned AFULL = DEPTH - 1;
   localparam logic [PW:0] CNT_FULL  = DEPTH[PW:0];
   localparam logic [PW:0] CNT_AFULL = AFULL[PW:0];

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_cnt;
   buf_entry_t    r_mem [DEPTH];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage needs no reset: the head is only observed while the count is non-zero.
   always_ff @(posedge i_clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_cnt == CNT_FULL);
   assign o_afull = (r_cnt == CNT_AFULL);
   assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC generation, redirect handling and a fetch buffer.
// Define FETCH_PERF_CNT_EN to add the fetch_count / stall_count performance outputs.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
   parameter int unsigned       BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [XLEN-1:0]   imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [XLEN-1:0]   instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              busy,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]       fetch_count,
   output logic [31:0]       stall_count,
`endif
   output logic              misalign_err
);

   fetch_state_t      r_state;
   fetch_state_t      w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic              r_err;
   logic              w_err_set;
   logic              w_push;
   logic              w_buf_pop;
   logic              w_flush;
   logic              w_full;
   logic              w_afull;
   logic              w_empty;
   logic              w_active;
   logic              w_pop;
   logic              w_redir_ok;
   logic              w_redir_bad;
   buf_entry_t        w_head;
   buf_entry_t        w_push_data;

   assign w_active    = (r_state == ST_FETCH) || (r_state == ST_STALL);
   assign instr_valid = w_active && !w_empty;
   assign w_pop       = instr_valid && instr_ready;
   assign w_redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
   assign w_redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_redir_bad) w_state_nxt = ST_ERROR;
            else if (start)  w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (w_redir_bad)     w_state_nxt = ST_ERROR;
            else if (w_redir_ok) w_state_nxt = ST_FETCH;
            else if (!w_pop && (w_full || w_afull)) w_state_nxt = ST_STALL;
         end
         ST_STALL: begin
            if (w_redir_bad)     w_state_nxt = ST_ERROR;
            else if (w_redir_ok) w_state_nxt = ST_FETCH;
            else if (w_pop)      w_state_nxt = ST_FETCH;
         end
         default: w_state_nxt = ST_ERROR;
      endcase
   end

   always_comb begin
      w_push    = 1'b0;
      w_buf_pop = 1'b0;
      w_flush   = 1'b0;
      w_err_set = 1'b0;
      w_pc_nxt  = r_pc;
      case (r_state)
         ST_IDLE: begin
            if (w_redir_bad) begin
               w_flush   = 1'b1;
               w_err_set = 1'b1;
            end else if (w_redir_ok) begin
               w_pc_nxt = redirect_pc;
            end
         end
         ST_FETCH, ST_STALL: begin
            if (redirect_valid) begin
               w_flush = 1'b1;
               if (w_redir_bad) w_err_set = 1'b1;
               else             w_pc_nxt  = redirect_pc;
            end else begin
               w_buf_pop = w_pop;
               // The pop that releases a stall does not also fetch.
               if ((r_state == ST_FETCH) && (!w_full || w_pop)) begin
                  w_push   = 1'b1;
                  w_pc_nxt = r_pc + ADDR_W'(4);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc  <= RESET_PC;
         r_err <= 1'b0;
      end else begin
         r_pc <= w_pc_nxt;
         if (w_err_set) r_err <= 1'b1;
      end
   end

   assign w_push_data.pc    = r_pc;
   assign w_push_data.instr = imem_rdata;

   fetch_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_push  (w_push),
      .i_pop   (w_buf_pop),
      .i_flush (w_flush),
      .i_data  (w_push_data),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_afull (w_afull),
      .o_empty (w_empty)
   );

   assign imem_addr    = r_pc;
   assign busy         = w_active;
   assign misalign_err = r_err;
   assign instr        = instr_valid ? w_head.instr : '0;
   assign instr_pc     = instr_valid ? w_head.pc    : '0;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_fetch_cnt <= r_fetch_cnt + 32'(w_push);
         r_stall_cnt <= r_stall_cnt + 32'(r_state == ST_STALL);
      end
   end

   assign fetch_count = r_fetch_cnt;
   assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic vs a queue model.
module tb_fetch_sequencer;

   localparam int unsigned D   = 2;
   localparam logic [15:0] RPC = 16'h0000;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [15:0] instr_pc;
   logic        busy;
   logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   fetch_sequencer #(
      .RESET_PC  (RPC),
      .BUF_DEPTH (D)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .busy           (busy),
`ifdef FETCH_PERF_CNT_EN
      .fetch_count    (fetch_count),
      .stall_count    (stall_count),
`endif
      .misalign_err   (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {a ^ 16'hC3A5, a + 16'h1357};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   // Reference model: mode 0 idle, 1 running, 2 error; a queue stands in for the buffer.
   typedef struct {
      logic [15:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        m_q[$];
   logic [15:0] m_pc;
   int          m_mode;
   bit          m_stall;
   bit          m_err;
   int unsigned m_fc;
   int unsigned m_sc;

   int n_vec;
   int n_miss;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_valid();
      return (m_mode == 1) && (m_q.size() > 0);
   endfunction

   task automatic m_reset();
      m_q.delete();
      m_pc    = RPC;
      m_mode  = 0;
      m_stall = 1'b0;
      m_err   = 1'b0;
      m_fc    = 0;
      m_sc    = 0;
   endtask

   task automatic m_go_err();
      m_q.delete();
      m_mode = 2;
      m_err  = 1'b1;
   endtask

   task automatic m_step(input logic s, input logic rv, input logic [15:0] rp, input logic rdy);
      bit   pop;
      bit   mis;
      ent_t e;
      pop = m_valid() && rdy;
      mis = rv && (rp[1:0] != 2'b00);
      if (m_mode == 1 && m_stall) m_sc++;
      case (m_mode)
         0: begin
            if (mis) m_go_err();
            else begin
               if (rv) m_pc = rp;
               if (s) begin
                  m_mode  = 1;
                  m_stall = 1'b0;
               end
            end
         end
         1: begin
            if (mis) m_go_err();
            else if (rv) begin
               m_q.delete();
               m_pc    = rp;
               m_stall = 1'b0;
            end else if (m_stall) begin
               if (pop) begin
                  m_q.delete(0);
                  m_stall = 1'b0;
               end
            end else begin
               if (pop) m_q.delete(0);
               if (m_q.size() < D) begin
                  e.pc  = m_pc;
                  e.ins = mem_word(m_pc);
                  m_q.push_back(e);
                  m_pc = m_pc + 16'd4;
                  m_fc++;
               end
               if (!pop && m_q.size() == D) m_stall = 1'b1;
            end
         end
         default: ;
      endcase
   endtask

   task automatic check_outputs();
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("busy", 32'(busy), 32'(m_mode == 1));
      chk("misalign_err", 32'(misalign_err), 32'(m_err));
      chk("instr_valid", 32'(instr_valid), 32'(m_valid()));
      if (m_valid()) begin
         chk("instr_pc", 32'(instr_pc), 32'(m_q[0].pc));
         chk("instr", instr, m_q[0].ins);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, m_fc);
      chk("stall_count", stall_count, m_sc);
`endif
   endtask

   // Called at a falling edge: compare, drive, advance the model, wait for the next falling edge.
   task automatic cycle(input logic s, input logic rv, input logic [15:0] rp, input logic rdy);
      check_outputs();
      start          = s;
      redirect_valid = rv;
      redirect_pc    = rp;
      instr_ready    = rdy;
      m_step(s, rv, rp, rdy);
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", 32'(instr_pc), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(misalign_err), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'(RPC));
      start          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;
      m_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic        s;
      logic        rv;
      logic        rdy;
      logic [15:0] rp;
      n_vec          = 0;
      n_miss         = 0;
      rst            = 1'b1;
      start          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;
      m_reset();
      @(negedge clk);
      @(negedge clk);

      // Straight-line fetch with ready held high.
      do_reset();
      cycle(1'b1, 1'b0, '0, 1'b1);
      chk("lat_n1_valid", 32'(instr_valid), 32'd0);
      cycle(1'b0, 1'b0, '0, 1'b1);
      chk("lat_n2_valid", 32'(instr_valid), 32'd1);
      chk("lat_n2_pc", 32'(instr_pc), 32'(RPC));
      for (int k = 1; k <= 3; k++) begin
         cycle(1'b0, 1'b0, '0, 1'b1);
         chk("seq_pc", 32'(instr_pc), 32'(4 * k));
      end

      // Back-pressure: fill, stall, then drain.
      do_reset();
      cycle(1'b1, 1'b0, '0, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0);
      chk("stall_addr", 32'(imem_addr), 32'h0008);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_head", 32'(instr_pc), 32'h0000);
      cycle(1'b0, 1'b0, '0, 1'b1);
      chk("drain_pc1", 32'(instr_pc), 32'h0004);
      cycle(1'b0, 1'b0, '0, 1'b1);
      chk("drain_pc2", 32'(instr_pc), 32'h0008);
      cycle(1'b0, 1'b0, '0, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0);
      do_reset();
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, '0, 1'b1);
      chk("post_rst_idle", 32'(busy), 32'd0);

      // Aligned redirect while fetching.
      do_reset();
      cycle(1'b1, 1'b0, '0, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b1);
      cycle(1'b0, 1'b1, 16'h0020, 1'b1);
      chk("redir_flush", 32'(instr_valid), 32'd0);
      chk("redir_addr", 32'(imem_addr), 32'h0020);
      cycle(1'b0, 1'b0, '0, 1'b1);
      chk("redir_pc", 32'(instr_pc), 32'h0020);

      // Misaligned redirect, then start and redirect are ignored.
      cycle(1'b0, 1'b1, 16'h0022, 1'b1);
      chk("mis_err", 32'(misalign_err), 32'd1);
      chk("mis_valid", 32'(instr_valid), 32'd0);
      cycle(1'b1, 1'b0, '0, 1'b1);
      cycle(1'b1, 1'b1, 16'h0040, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b1);
      chk("mis_busy", 32'(busy), 32'd0);

      // Wrap at the top of the address space.
      do_reset();
      cycle(1'b1, 1'b0, '0, 1'b1);
      cycle(1'b0, 1'b1, 16'hFFF8, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b1);
      chk("wrap_pc0", 32'(instr_pc), 32'hFFF8);
      cycle(1'b0, 1'b0, '0, 1'b1);
      chk("wrap_pc1", 32'(instr_pc), 32'hFFFC);
      cycle(1'b0, 1'b0, '0, 1'b1);
      chk("wrap_pc2", 32'(instr_pc), 32'h0000);
      chk("wrap_err", 32'(misalign_err), 32'd0);

      // Redirects taken in IDLE.
      do_reset();
      cycle(1'b0, 1'b1, 16'h0080, 1'b1);
      chk("idle_redir_busy", 32'(busy), 32'd0);
      chk("idle_redir_addr", 32'(imem_addr), 32'h0080);
      cycle(1'b1, 1'b1, 16'h0100, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b1);
      chk("idle_start_pc", 32'(instr_pc), 32'h0100);

      // Randomized episodes.
      for (int ep = 0; ep < 16; ep++) begin
         do_reset();
         cycle(1'b1, 1'b0, '0, 1'b1);
         for (int c = 0; c < 120; c++) begin
            s  = ($urandom_range(0, 7) == 0);
            rv = ($urandom_range(0, 19) == 0);
            rp = 16'($urandom);
            if ($urandom_range(0, 7) != 0) rp[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) rp[15:4] = '1;
            case (ep % 3)
               0:       rdy = 1'b1;
               1:       rdy = ($urandom_range(0, 1) == 0);
               default: rdy = ($urandom_range(0, 4) == 0);
            endcase
            cycle(s, rv, rp, rdy);
         end
      end
      check_outputs();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
